serial_mod_n_checker: RTL
=========================

// Module: serial_mod_n_checker
// PURPOSE
//  Serial divisibility checker: parametrised successor of the mod-3 bit-serial FSM.
//  Accepts one bit per cycle under a valid qualifier and tracks the running remainder of
//  the received binary number mod DIVISOR. Supports MSB- or LSB-first order and
//  fixed-length frames with per-frame result capture. Sits after serial-link deserialiser front-ends.
// PARAMETERS
//  DIVISOR    3  modulus, 2..255; REM_W = $clog2(DIVISOR) (localparam, min 1)
//  FRAME_LEN  8  bits per frame, 1..1024; CNT_W = $clog2(FRAME_LEN+1) (localparam)
//  MSB_FIRST  1  1: first bit is MSB; 0: first bit is LSB
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      asynchronous, active-low reset
//  inp_valid  in   1      inp carries a bit this cycle
//  inp        in   1      serial data bit
//  sof        in   1      start-of-frame; meaningful only with inp_valid=1
//  outp       out  1      1 = running value divisible by DIVISOR (rem_out==0)
//  rem_out    out  REM_W  running remainder
//  bit_cnt    out  CNT_W  bits accepted in current frame
//  frame_done out  1      one-cycle pulse: last bit of a frame accepted
//  frame_rem  out  REM_W  remainder of last completed frame (held)
// BEHAVIOUR
//  - Reset (rst=0, async): state=S_IDLE, rem_out=0, outp=1, bit_cnt=0, frame_done=0,
//    frame_rem=0, weight=1 mod DIVISOR. Reset mid-frame discards the frame, no frame_done.
//  - All outputs registered; latency 1 cycle from accepted bit to updated outputs.
//  - Accept = inp_valid=1 at rising edge. inp_valid=0: all state held, frame_done=0.
//  - FSM: S_IDLE (no partial frame), S_ACC (partial frame in progress).
//    S_IDLE + accept: base rem=0, weight=1, bit_cnt->1; ->S_ACC, or stay S_IDLE with
//      frame_done=1 if FRAME_LEN==1.
//    S_ACC + accept + sof=1: abandon current frame (no frame_done); bit treated as
//      first bit of new frame exactly as from S_IDLE.
//    S_ACC + accept, bit_cnt==FRAME_LEN-1: final bit; ->S_IDLE, frame_done=1,
//      frame_rem<=new rem, bit_cnt<=FRAME_LEN (held until next accept).
//    S_ACC + accept otherwise: bit_cnt+1, stay.
//    sof in S_IDLE: no extra effect. sof with inp_valid=0: ignored.
//  - Remainder update (base rem r, bit b):
//    MSB_FIRST=1: r' = (2*r + b) mod DIVISOR.
//    MSB_FIRST=0: r' = (r + b*w) mod DIVISOR; w' = (2*w) mod DIVISOR.
//    Intermediates REM_W+1 bits wide; reduce by single conditional subtract (no '%').
//  - In S_IDLE after a frame, rem_out/outp keep the completed frame result.
//  - frame_done never asserts two consecutive cycles unless FRAME_LEN==1 and
//    accepts are back-to-back.
// TESTING
//  1 DIVISOR=3,MSB,FRAME_LEN=10; bits 0,1,0,1,1,0,1,0,0,1 back-to-back -> outp after
//    each: 1,0,0,0,0,0,1,1,1,0; frame_done once after 10th; frame_rem=1 (361 mod 3).
//  2 DIVISOR=5,LSB,FRAME_LEN=4; bits 1,0,1,0 -> rem_out 1,1,0,0; frame_rem=0, outp=1.
//  3 Test 1 stimulus with inp_valid=0 gaps of 1-3 cycles inserted -> identical
//    outp/rem sequence per accepted bit; nothing changes during gaps.
//  4 DIVISOR=3,FRAME_LEN=8: 5 bits, then sof=1 with bit 1 -> bit_cnt=1, rem_out=1,
//    no frame_done; 7 more bits complete frame normally.
//  5 Reset pulse (rst=0) mid-frame, async to clk -> outputs reset immediately;
//    next bit starts new frame, bit_cnt=1.
//  6 DIVISOR=7,MSB,FRAME_LEN=1; bits 1,1 -> frame_done two consecutive cycles,
//    frame_rem=1 each; random sweep vs. reference model for DIVISOR 2..13.

Source files
------------

// File: rtl/serial_mod_n_checker.sv
// Bit-serial divisibility checker: tracks the running remainder of a framed
// binary number modulo DIVISOR, MSB- or LSB-first, with per-frame result capture.
module serial_mod_n_checker #(
  parameter int DIVISOR   = 3,
  parameter int FRAME_LEN = 8,
  parameter int MSB_FIRST = 1,
  localparam int REM_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  input  logic             inp,
  input  logic             sof,
  output logic             outp,
  output logic [REM_W-1:0] rem_out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done,
  output logic [REM_W-1:0] frame_rem,
  output logic             state_dbg
);

  // Handshake: a bit is consumed on every rising edge where inp_valid=1; there is
  // no backpressure, and sof is only looked at on those same edges.

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  localparam logic [REM_W:0]   DIV_X = (REM_W + 1)'(DIVISOR);
  localparam logic [REM_W-1:0] ONE_W = REM_W'(1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);

  state_t           state_q, state_n;
  logic [REM_W-1:0] rem_q, rem_n, w_q, w_n, frem_q, frem_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             outp_q, outp_n, done_q, done_n;
  logic             first;
  logic [REM_W-1:0] base_r, base_w, new_r;
  logic [REM_W:0]   sum, dbl_w;

  // Every intermediate is below 2*DIVISOR, so one conditional subtract reduces it.
  function automatic logic [REM_W-1:0] reduce(input logic [REM_W:0] x);
    reduce = (x >= DIV_X) ? REM_W'(x - DIV_X) : x[REM_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    w_n     = w_q;
    frem_n  = frem_q;
    cnt_n   = cnt_q;
    outp_n  = outp_q;
    done_n  = 1'b0;

    // A bit in IDLE, or any bit flagged sof, restarts the frame from zero.
    first  = (state_q == S_IDLE) || sof;
    base_r = first ? '0 : rem_q;
    base_w = first ? ONE_W : w_q;
    if (MSB_FIRST != 0) sum = {base_r, inp};
    else                sum = {1'b0, base_r} + (inp ? {1'b0, base_w} : '0);
    dbl_w = {base_w, 1'b0};
    new_r = reduce(sum);

    if (inp_valid) begin
      rem_n  = new_r;
      w_n    = reduce(dbl_w);
      outp_n = (new_r == '0);
      cnt_n  = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
      if (cnt_n == LEN_C) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        frem_n  = new_r;
      end else begin
        state_n = S_ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      w_q    <= ONE_W;
      frem_q <= '0;
      cnt_q  <= '0;
      outp_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_n;
      w_q    <= w_n;
      frem_q <= frem_n;
      cnt_q  <= cnt_n;
      outp_q <= outp_n;
      done_q <= done_n;
    end
  end

  assign outp       = outp_q;
  assign rem_out    = rem_q;
  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;
  assign frame_rem  = frem_q;
  assign state_dbg  = state_q;

endmodule
